mem_port_arbiter: RTL

Arbitrates the single shared RAM port between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage core. It issues one RAM access per cycle and tracks which requester owns the in-flight access. It routes the next-cycle read data back to that requester and drives per-stage stall outputs into the hazard unit. Data accesses normally win; a starvation guard, compiled in by macro, bounds how long fetch can be locked out.

---
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single RAM port between instruction fetch and
// the load/store stage. One access is granted per cycle; the response comes
// back one cycle later and is routed to the owner of the in-flight access.
// Optional feature macro: MEM_ARB_STARVE_EN enables the fetch starvation guard.
module mem_port_arbiter #(
    parameter logic [63:0] PC_START   = 64'h8000_0000,
    parameter int          STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_req,
    input  logic [63:0] inst_addr,
    output logic        inst_gnt,
    output logic        inst_rvalid,
    output logic [63:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [63:0] data_addr,
    input  logic [63:0] data_wdata,
    input  logic [63:0] data_wmask,
    output logic        data_gnt,
    output logic        data_done,
    output logic [63:0] data_rdata,
    output logic        ram_en,
    output logic [63:0] ram_ridx,
    input  logic [63:0] ram_rdata,
    output logic        ram_wen,
    output logic [63:0] ram_widx,
    output logic [63:0] ram_wdata,
    output logic [63:0] ram_wmask,
    output logic        if_stall,
    output logic        me_stall
);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_INST = 2'd1;
    localparam logic [1:0] OWN_DATA = 2'd2;

    // The counter is 4 bits wide, so the limit must fit in 1..15.
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_starve_range
        $error("mem_port_arbiter: STARVE_MAX must be in 1..15");
    end

    logic [1:0]  own_q, own_d;
    logic        st_q, st_d;
    logic [63:0] inst_idx, data_idx;
    logic        data_rd;

`ifdef MEM_ARB_STARVE_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    logic [3:0] starve_q, starve_d;
`endif

    // Grant: lone requester wins; on a collision data wins unless fetch has
    // been starved long enough. Everything is forced low while in reset.
    always_comb begin
        inst_gnt = 1'b0;
        data_gnt = 1'b0;
        if (rst_n) begin
            if (inst_req && data_req) begin
`ifdef MEM_ARB_STARVE_EN
                inst_gnt = (starve_q == STARVE_LIM);
`else
                inst_gnt = 1'b0;
`endif
                data_gnt = !inst_gnt;
            end else begin
                inst_gnt = inst_req;
                data_gnt = data_req;
            end
        end
    end

    // RAM request side: byte addresses become doubleword indices relative to
    // PC_START with plain 64-bit wrap; unused fields are held at zero.
    always_comb begin
        inst_idx  = (inst_addr - PC_START) >> 3;
        data_idx  = (data_addr - PC_START) >> 3;
        data_rd   = data_gnt && !data_we;
        ram_en    = inst_gnt || data_rd;
        ram_ridx  = inst_gnt ? inst_idx : (data_rd ? data_idx : 64'd0);
        ram_wen   = data_gnt && data_we;
        ram_widx  = ram_wen ? data_idx   : 64'd0;
        ram_wdata = ram_wen ? data_wdata : 64'd0;
        ram_wmask = ram_wen ? data_wmask : 64'd0;
    end

    // Response side: route registered RAM data to whoever owned last cycle's
    // access. A completing store returns zero data.
    always_comb begin
        inst_rvalid = (own_q == OWN_INST);
        data_done   = (own_q == OWN_DATA);
        inst_rdata  = inst_rvalid ? ram_rdata : 64'd0;
        data_rdata  = (data_done && !st_q) ? ram_rdata : 64'd0;
    end

    // Stalls to the hazard unit. The outstanding term is kept for clarity;
    // every access completes in its response cycle so it never fires alone.
    always_comb begin
        if_stall = rst_n && inst_req && !inst_gnt;
        me_stall = rst_n && ((data_req && !data_gnt) ||
                             ((own_q == OWN_DATA) && !data_done));
    end

    // Next owner, store flag and starvation count.
    always_comb begin
        own_d = inst_gnt ? OWN_INST : (data_gnt ? OWN_DATA : OWN_NONE);
        st_d  = data_gnt && data_we;
`ifdef MEM_ARB_STARVE_EN
        starve_d = 4'd0;
        if (inst_req && !inst_gnt)
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 4'd1;
`endif
    end

    // State registers; reset drops any in-flight response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_q    <= OWN_NONE;
            st_q     <= 1'b0;
`ifdef MEM_ARB_STARVE_EN
            starve_q <= 4'd0;
`endif
        end else begin
            own_q    <= own_d;
            st_q     <= st_d;
`ifdef MEM_ARB_STARVE_EN
            starve_q <= starve_d;
`endif
        end
    end

endmodule
